fifo_axis_master: RTL
=====================

Name: fifo_axis_master

Overview:
- Read-side drain stage for the async FIFO. Runs in the FIFO read clock domain.
- Pops words through the FIFO read port and presents them as an AXI4-Stream master, with full backpressure and 1 beat/cycle throughput.
- Generates tlast every PKT_LEN beats and counts completed packets.
- Holds a 2-entry output buffer that absorbs the FIFO's 1-cycle registered read latency.

Parameters:
- DATA_WIDTH, 32, width of fifo_dout and m_axis_tdata.
- PKT_LEN, 256, beats per packet; legal range is >= 1.
- CNT_WIDTH, 16, width of pkt_count.

Ports:
- clk  in  1  FIFO read clock (same net as FIFO rd_clk).
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = new FIFO reads may be issued; 0 = issue no new reads, but drain buffered and in-flight words.
- fifo_dout  in  DATA_WIDTH  FIFO read data; valid the cycle after a pop.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO pop request.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of packet.
- pkt_count  out  CNT_WIDTH  completed packets; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset, sampled on posedge clk while rst=1:
  - clears occupancy (0..2), inflight flag, head/tail pointers, beat_cnt and pkt_count;
  - all outputs = 0, including fifo_rd_en (gated by rst combinationally).
- Reset mid-packet:
  - buffered words and any in-flight word are discarded;
  - beat_cnt restarts at 0, so the next beat starts a new packet;
  - the FIFO read side must be reset in the same cycle.
- Definitions:
  - hs = m_axis_tvalid & m_axis_tready.
  - inflight = 1 in the cycle after fifo_rd_en=1.
- Pop issue (combinational): fifo_rd_en = !rst & en & !fifo_empty & ((occ + inflight < 2) | hs).
  - Never asserted while fifo_empty=1, so every fifo_rd_en is a real pop.
- Capture: on each edge with inflight=1, fifo_dout is written at the buffer tail.
- Occupancy update per edge: occ_next = occ + inflight - hs.
  - Simultaneous capture and handshake leave occ unchanged.
  - occ never exceeds 2; overflow is impossible by construction and is asserted in simulation.
- Output:
  - m_axis_tvalid = (occ != 0); m_axis_tdata = buffer head.
  - No bypass path from fifo_dout to tdata.
- Latency: fifo_rd_en high in cycle k -> fifo_dout valid in cycle k+1 -> tvalid/tdata in cycle k+2, when the buffer was empty.
- Throughput: with tready held at 1 and the FIFO non-empty, one beat per cycle sustained after the 2-cycle fill.
- AXIS stability: once tvalid=1, tdata and tlast hold until hs. tvalid never drops without hs (except on rst).
- Packet counter:
  - beat_cnt (width $clog2(PKT_LEN)+1) increments on hs.
  - m_axis_tlast = (beat_cnt == PKT_LEN-1) & m_axis_tvalid.
  - On hs with tlast=1: beat_cnt <= 0 and pkt_count <= pkt_count + 1.
  - PKT_LEN=1: every beat has tlast=1.
- en deassert: no new pops next cycle. Words already buffered or in flight are still delivered, and beat_cnt is preserved across en toggles.
- FIFO empty mid-packet: tvalid drops after the buffer drains. The packet resumes when data arrives; tlast position is unaffected.
- Throughout, the block never pops more than it can store and never loses or duplicates a word.

Test Plan:
- Reset / idle: rst high 3 cycles with fifo_empty=0 -> fifo_rd_en=0, tvalid=0, tlast=0, pkt_count=0 throughout. After release with en=1, fifo_rd_en=1 on the first cycle.
- Streaming, PKT_LEN=4: FIFO preloaded with 0x00..0x0B, tready=1 -> 12 consecutive beats 0x00..0x0B with no gaps after the first beat (which appears 2 cycles after the first rd_en). tlast on 0x03, 0x07, 0x0B; pkt_count ends at 3.
- Backpressure: tready toggles 1,0,0,1,... with random stalls over 64 words -> data in order, no loss or duplication, occ <= 2. tdata and tlast stable while tvalid=1 & tready=0.
- Empty mid-packet, PKT_LEN=4: FIFO holds 2 words, then 2 more arrive 10 cycles later -> tvalid low during the gap. tlast only on the 4th word; pkt_count = 1.
- en deassert: en drops in the same cycle as a pop with 1 word buffered -> both words (buffered and in-flight) are delivered, then no pops until en=1.
- Reset mid-packet: rst after beat 2 of 4 with 2 words buffered -> outputs 0 next cycle. After refill, the first delivered beat starts a new packet: tlast after 4 more beats, pkt_count = 1.

Source files
------------

// File: rtl/fifo_axis_master.sv
// fifo_axis_master: drains a registered-read FIFO into an AXI4-Stream master with tlast framing.
// A 2-entry skid buffer absorbs the one-cycle FIFO read latency so backpressure never drops a word.
module fifo_axis_master #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [CNT_WIDTH-1:0]  pkt_count
);
  localparam int BW = $clog2(PKT_LEN) + 1;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, head_q, tail_q, hs;
  logic [BW-1:0]         beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  pkt_q;
  assign m_axis_tvalid = occ_q != 2'd0;
  assign m_axis_tdata  = buf_q[head_q];
  assign m_axis_tlast  = m_axis_tvalid & (beat_q == BW'(PKT_LEN - 1));
  assign pkt_count     = pkt_q;
  assign hs            = m_axis_tvalid & m_axis_tready;
  // Count the in-flight word as already occupying a slot; a handshake frees one this cycle.
  assign fifo_rd_en = !rst & en & !fifo_empty & ((({1'b0, occ_q} + {2'b0, inflight_q}) < 3'd2) | hs);
  always_comb begin
    occ_d  = occ_q + {1'b0, inflight_q} - {1'b0, hs};
    beat_d = hs ? (m_axis_tlast ? '0 : beat_q + 1'b1) : beat_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      beat_q     <= '0;
      pkt_q      <= '0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      beat_q     <= beat_d;
      if (inflight_q) begin
        buf_q[tail_q] <= fifo_dout;
        tail_q        <= !tail_q;
      end
      if (hs) head_q <= !head_q;
      if (hs & m_axis_tlast) pkt_q <= pkt_q + 1'b1;
    end
  end
  occ_bound: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, occ_q} + {2'b0, inflight_q}) <= 3'd2);
endmodule
